// File: rtl/mwc_pkg.sv
// Shared types for the data-memory write checker: FSM state and failure cause encodings.
package mwc_pkg;

    typedef enum logic [1:0] {
        RUN,
        PASS,
        FAIL
    } mwc_state_t;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_ILLEGAL,
        FC_BADDATA,
        FC_LIMIT
    } mwc_fail_t;

endpackage

// File: rtl/mem_write_checker_if.sv
// Snoop bus between the CPU data-memory write port and the write checker.
// The master side drives the store strobe and bus; the slave side returns the verdict.
interface mem_write_checker_if
    import mwc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WC_W  = 5,
    parameter int CC_W  = 7
);
    logic             en;
    logic             memwrite;
    logic [WIDTH-1:0] aluout;
    logic [WIDTH-1:0] writedata;
    logic             done;
    logic             pass;
    logic             fail;
    mwc_fail_t        fail_code;
    logic [WC_W-1:0]  write_count;
    logic [CC_W-1:0]  cycle_count;
    logic [WIDTH-1:0] bad_addr;

    modport master (
        output en, memwrite, aluout, writedata,
        input  done, pass, fail, fail_code, write_count, cycle_count, bad_addr
    );

    modport slave (
        input  en, memwrite, aluout, writedata,
        output done, pass, fail, fail_code, write_count, cycle_count, bad_addr
    );
endinterface

// File: rtl/addr_whitelist.sv
// Combinational match of a store address against a fixed table of legal addresses.
// An empty table never hits.
module addr_whitelist #(
    parameter int WIDTH       = 32,
    parameter int NUM_ALLOWED = 4,
    parameter logic [((NUM_ALLOWED > 0) ? NUM_ALLOWED : 1)*WIDTH-1:0] ALLOWED_ADDRS =
        {32'h34, 32'h20, 32'h1C, 32'h18}
) (
    input  logic [WIDTH-1:0] addr_i,
    output logic             hit_o
);

    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < NUM_ALLOWED; i++) begin
            if (addr_i == ALLOWED_ADDRS[i*WIDTH +: WIDTH]) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor for the CPU data-memory write port: sticky PASS on the target store,
// sticky FAIL on an illegal address, bad target data, too many stores, or timeout.
//
// state | meaning
// RUN   | monitoring stores and counting enabled cycles
// PASS  | target store seen with correct data (terminal until reset)
// FAIL  | error latched in fail_code/bad_addr (terminal until reset)
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int NUM_ALLOWED    = 4,
    parameter logic [((NUM_ALLOWED > 0) ? NUM_ALLOWED : 1)*WIDTH-1:0] ALLOWED_ADDRS =
        {32'h34, 32'h20, 32'h1C, 32'h18},
    parameter logic [WIDTH-1:0] TARGET_ADDR = 32'h14,
    parameter logic [WIDTH-1:0] TARGET_DATA = 32'h1C,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_WRITES     = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_write_checker_if.slave bus
);

    localparam int WC_W = $clog2(MAX_WRITES + 1);
    localparam int CC_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WRITES);
    localparam logic [CC_W-1:0] CC_MAX = CC_W'(TIMEOUT_CYCLES);

    mwc_state_t       state_q;
    logic             done_q;
    logic             pass_q;
    logic             fail_q;
    mwc_fail_t        fail_code_q;
    logic [WC_W-1:0]  write_count_q;
    logic [CC_W-1:0]  cycle_count_q;
    logic [WIDTH-1:0] bad_addr_q;

    logic             wl_hit;
    logic             is_target_d;
    logic             data_ok_d;
    logic [WC_W-1:0]  write_count_d;
    logic [CC_W-1:0]  cycle_count_d;

    addr_whitelist #(
        .WIDTH         (WIDTH),
        .NUM_ALLOWED   (NUM_ALLOWED),
        .ALLOWED_ADDRS (ALLOWED_ADDRS)
    ) u_whitelist (
        .addr_i (bus.aluout),
        .hit_o  (wl_hit)
    );

    always_comb begin
        is_target_d   = (bus.aluout == TARGET_ADDR);
        data_ok_d     = (bus.writedata == TARGET_DATA);
        write_count_d = (write_count_q == WC_MAX) ? write_count_q : write_count_q + 1'b1;
        cycle_count_d = (cycle_count_q == CC_MAX) ? cycle_count_q : cycle_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_code_q   <= FC_NONE;
            write_count_q <= '0;
            cycle_count_q <= '0;
            bad_addr_q    <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.en) begin
                        cycle_count_q <= cycle_count_d;
                        // Target rules override the whitelist even if the target is listed.
                        if (bus.memwrite && is_target_d && data_ok_d) begin
                            state_q <= PASS;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else if (bus.memwrite && is_target_d) begin
                            state_q     <= FAIL;
                            done_q      <= 1'b1;
                            fail_q      <= 1'b1;
                            fail_code_q <= FC_BADDATA;
                            bad_addr_q  <= bus.aluout;
                        end else if (bus.memwrite && !wl_hit) begin
                            state_q     <= FAIL;
                            done_q      <= 1'b1;
                            fail_q      <= 1'b1;
                            fail_code_q <= FC_ILLEGAL;
                            bad_addr_q  <= bus.aluout;
                        end else begin
                            if (bus.memwrite) begin
                                write_count_q <= write_count_d;
                            end
                            if ((bus.memwrite && write_count_d == WC_MAX) ||
                                cycle_count_d == CC_MAX) begin
                                state_q     <= FAIL;
                                done_q      <= 1'b1;
                                fail_q      <= 1'b1;
                                fail_code_q <= FC_LIMIT;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.fail_code   = fail_code_q;
    assign bus.write_count = write_count_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.bad_addr    = bad_addr_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus randomized stores, checked every
// cycle against a rule-level model of the monitor, with literal pins on key results.
module tb_mem_write_checker;
    import mwc_pkg::*;

    localparam int          TIMEOUT = 64;
    localparam int          MAXW    = 16;
    localparam logic [31:0] TA      = 32'h14;
    localparam logic [31:0] TD      = 32'h1C;
    localparam logic [31:0] WL [4]  = '{32'h18, 32'h1C, 32'h20, 32'h34};

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_write_checker_if #(.WIDTH(32), .WC_W(5), .CC_W(7)) bus ();

    mem_write_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    // Model state: verdict flags, cause, counts and failing address.
    bit          m_pass = 1'b0;
    bit          m_fail = 1'b0;
    int          m_code = 0;
    int          m_wc   = 0;
    int          m_cc   = 0;
    logic [31:0] m_bad  = '0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit allowed(logic [31:0] a);
        foreach (WL[i]) if (WL[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_fail(int code, logic [31:0] a);
        m_fail = 1'b1;
        m_code = code;
        m_bad  = a;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_pass = 0; m_fail = 0; m_code = 0; m_wc = 0; m_cc = 0; m_bad = '0;
        end else if (!(m_pass || m_fail) && bus.en) begin
            if (m_cc < TIMEOUT) m_cc = m_cc + 1;
            if (bus.memwrite) begin
                if (bus.aluout == TA) begin
                    if (bus.writedata == TD) m_pass = 1'b1;
                    else model_fail(2, bus.aluout);
                end else if (!allowed(bus.aluout)) begin
                    model_fail(1, bus.aluout);
                end else begin
                    m_wc = m_wc + 1;
                    if (m_wc >= MAXW) model_fail(3, '0);
                end
            end
            if (!(m_pass || m_fail) && m_cc >= TIMEOUT) model_fail(3, '0);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("done",        64'(bus.done),        64'(m_pass | m_fail));
            chk("pass",        64'(bus.pass),        64'(m_pass));
            chk("fail",        64'(bus.fail),        64'(m_fail));
            chk("fail_code",   64'(bus.fail_code),   64'(m_code));
            chk("write_count", 64'(bus.write_count), 64'(m_wc));
            chk("cycle_count", 64'(bus.cycle_count), 64'(m_cc));
            chk("bad_addr",    64'(bus.bad_addr),    64'(m_bad));
        end
    end

    task automatic step(bit e, bit mw, logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        bus.en        = e;
        bus.memwrite  = mw;
        bus.aluout    = a;
        bus.writedata = d;
    endtask

    task automatic pause();
        step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.en = 1'b0; bus.memwrite = 1'b0; bus.aluout = '0; bus.writedata = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bus.en = 1'b0; bus.memwrite = 1'b0; bus.aluout = '0; bus.writedata = '0;
        do_reset();
        chk_on = 1'b1;
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_cc",   64'(bus.cycle_count), 64'd0);

        // Legal stores then the target store.
        step(1, 1, 32'h18, 32'h55);
        step(1, 1, 32'h1C, 32'h3);
        step(1, 1, TA, TD);
        pause();
        chk("t1_pass", 64'(bus.pass), 64'd1);
        chk("t1_fail", 64'(bus.fail), 64'd0);
        chk("t1_wc",   64'(bus.write_count), 64'd2);

        // Illegal address is sticky even after a later target hit.
        do_reset();
        step(1, 1, 32'h40, 32'h7);
        pause();
        chk("t2_code", 64'(bus.fail_code), 64'd1);
        chk("t2_bad",  64'(bus.bad_addr), 64'h40);
        step(1, 1, TA, TD);
        pause();
        chk("t2_sticky_fail", 64'(bus.fail), 64'd1);
        chk("t2_no_pass",     64'(bus.pass), 64'd0);

        // Wrong data at the target.
        do_reset();
        step(1, 1, TA, 32'h1B);
        pause();
        chk("t3_code", 64'(bus.fail_code), 64'd2);
        chk("t3_bad",  64'(bus.bad_addr), 64'h14);

        // Timeout after 64 enabled cycles.
        do_reset();
        repeat (63) step(1, 0, '0, '0);
        pause();
        chk("t4_no_fail_63", 64'(bus.fail), 64'd0);
        step(1, 0, '0, '0);
        pause();
        chk("t4_fail_64", 64'(bus.fail_code), 64'd3);
        chk("t4_cc_64",   64'(bus.cycle_count), 64'd64);

        // Enable on odd cycles only: 128 cycles to time out.
        do_reset();
        for (int i = 0; i < 127; i++) step(i[0], 0, '0, '0);
        pause();
        chk("t4b_no_fail_127", 64'(bus.fail), 64'd0);
        step(1, 0, '0, '0);
        pause();
        chk("t4b_fail_128", 64'(bus.fail_code), 64'd3);

        // Write limit.
        do_reset();
        repeat (15) step(1, 1, 32'h20, 32'h1);
        pause();
        chk("t5_no_fail_15", 64'(bus.fail), 64'd0);
        step(1, 1, 32'h20, 32'h1);
        pause();
        chk("t5_code", 64'(bus.fail_code), 64'd3);
        chk("t5_wc",   64'(bus.write_count), 64'd16);
        chk("t5_bad",  64'(bus.bad_addr), 64'd0);

        // Target hit on the timeout cycle wins.
        do_reset();
        repeat (63) step(1, 0, '0, '0);
        step(1, 1, TA, TD);
        pause();
        chk("t5b_pass", 64'(bus.pass), 64'd1);
        chk("t5b_fail", 64'(bus.fail), 64'd0);

        // Mid-run reset clears everything.
        do_reset();
        repeat (5) step(1, 1, 32'h18, 32'h9);
        do_reset();
        chk("t6_wc_clear", 64'(bus.write_count), 64'd0);
        chk("t6_cc_clear", 64'(bus.cycle_count), 64'd0);
        step(1, 1, TA, TD);
        pause();
        chk("t6_pass", 64'(bus.pass), 64'd1);

        // Randomized rounds against the model.
        for (int r = 0; r < 25; r++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                case ($urandom_range(0, 9))
                    0:       a = TA;
                    1, 2:    a = $urandom & 32'hFC;
                    default: a = WL[$urandom_range(0, 3)];
                endcase
                d = ($urandom_range(0, 1) == 0) ? TD : 32'($urandom_range(0, 255));
                if ($urandom_range(0, 99) < 2) begin
                    do_reset();
                end else begin
                    step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, a, d);
                end
            end
        end
        pause();
        pause();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
